// File: rtl/cve2_pkg.sv
// Shared types for the custom-0 coprocessor on the X interface.
// Opcode constant, operation and state encodings, operand masks.
package cve2_pkg;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  typedef enum logic [2:0] {
    COP_CADD   = 3'b000,
    COP_CMUL16 = 3'b001,
    COP_CMAC   = 3'b010,
    COP_CPOPC  = 3'b011
  } xif_cop_op_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_OPERANDS = 2'd1,
    S_EXEC     = 2'd2,
    S_RESULT   = 2'd3
  } xif_cop_state_e;

  // Bit i set means rs(i+1) is read by the operation.
  function automatic logic [2:0] cop_rd_mask(
    input xif_cop_op_e op
  );
    logic [2:0] m;
    m = 3'b000;
    unique case (op)
      COP_CADD:   m = 3'b011;
      COP_CMUL16: m = 3'b011;
      COP_CMAC:   m = 3'b111;
      COP_CPOPC:  m = 3'b001;
      default:    m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] cop_popcount(
    input logic [31:0] v
  );
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {31'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/cve2_xif_coproc_alu.sv
// Combinational datapath of the custom-0 coprocessor.
// Products are 16x16 unsigned; all sums wrap mod 2^32.
module cve2_xif_coproc_alu
  import cve2_pkg::*;
(
  input  xif_cop_op_e i_op,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [31:0] i_rs3,
  output logic [31:0] o_res
);

  logic [31:0] w_prod;

  assign w_prod = {16'd0, i_rs1[15:0]} * {16'd0, i_rs2[15:0]};

  always_comb begin
    o_res = '0;
    unique case (i_op)
      COP_CADD:   o_res = i_rs1 + i_rs2;
      COP_CMUL16: o_res = w_prod;
      COP_CMAC:   o_res = w_prod + i_rs3;
      COP_CPOPC:  o_res = cop_popcount(i_rs1);
      default:    o_res = '0;
    endcase
  end

endmodule

// File: rtl/cve2_xif_coproc.sv
// Custom-0 X-interface coprocessor: issue decode, operand/commit
// collection, fixed-latency execute and result handshake.
module cve2_xif_coproc
  import cve2_pkg::*;
#(
  parameter int unsigned ExecLatency = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        xif_issue_valid_i,
  input  logic [31:0] xif_issue_req_instr_i,
  output logic        xif_issue_ready_o,
  output logic        xif_issue_resp_accept_o,
  output logic        xif_issue_resp_writeback_o,
  output logic [2:0]  xif_issue_resp_register_read_o,
  input  logic [31:0] xif_register_rs1_i,
  input  logic [31:0] xif_register_rs2_i,
  input  logic [31:0] xif_register_rs3_i,
  input  logic [2:0]  xif_register_rs_valid_i,
  input  logic        xif_commit_valid_i,
  input  logic        xif_commit_kill_i,
  input  logic        xif_result_ready_i,
  output logic        xif_result_valid_o,
  output logic        xif_result_we_o,
  output logic [31:0] xif_result_data_o
);

  localparam logic [3:0] LAT = 4'(ExecLatency);

  xif_cop_state_e r_state;
  xif_cop_op_e    r_op;
  logic [3:0]     r_cnt;
  logic           r_wb;
  logic [2:0]     r_need;
  logic [2:0]     r_got;
  logic           r_commit;
  logic [31:0]    r_rs1;
  logic [31:0]    r_rs2;
  logic [31:0]    r_rs3;
  logic           r_ready;
  logic           r_valid;
  logic           r_we;
  logic [31:0]    r_data;

  logic [2:0]     w_f3;
  logic           w_accept;
  logic           w_wb;
  logic [2:0]     w_rr;
  logic [2:0]     w_got;
  logic           w_all;
  logic           w_cmt;
  logic           w_kill;
  logic [31:0]    w_res;

  assign w_f3 = xif_issue_req_instr_i[14:12];

  always_comb begin
    w_accept = 1'b0;
    w_wb     = 1'b0;
    w_rr     = 3'b000;
    if (xif_issue_valid_i &&
        xif_issue_req_instr_i[6:0] == OPC_CUSTOM0 &&
        !w_f3[2]) begin
      w_accept = 1'b1;
      w_wb     = xif_issue_req_instr_i[11:7] != 5'd0;
      w_rr     = cop_rd_mask(xif_cop_op_e'(w_f3));
    end
  end

  assign xif_issue_resp_accept_o        = w_accept;
  assign xif_issue_resp_writeback_o     = w_wb;
  assign xif_issue_resp_register_read_o = w_rr;

  // Operand and commit status including this cycle's strobes.
  assign w_got  = r_got | (r_need & xif_register_rs_valid_i);
  assign w_all  = w_got == r_need;
  assign w_cmt  = r_commit | xif_commit_valid_i;
  assign w_kill = xif_commit_valid_i & xif_commit_kill_i & ~r_commit;

  cve2_xif_coproc_alu u_alu (
    .i_op  (r_op),
    .i_rs1 (r_rs1),
    .i_rs2 (r_rs2),
    .i_rs3 (r_rs3),
    .o_res (w_res)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_op     <= COP_CADD;
      r_cnt    <= '0;
      r_wb     <= 1'b0;
      r_need   <= '0;
      r_got    <= '0;
      r_commit <= 1'b0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rs3    <= '0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_we     <= 1'b0;
      r_data   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (xif_issue_valid_i && w_accept) begin
            r_op     <= xif_cop_op_e'(w_f3);
            r_wb     <= w_wb;
            r_need   <= w_rr;
            r_got    <= '0;
            r_commit <= 1'b0;
            r_ready  <= 1'b0;
            r_state  <= S_OPERANDS;
          end
        end
        S_OPERANDS: begin
          if (r_need[0] && xif_register_rs_valid_i[0])
            r_rs1 <= xif_register_rs1_i;
          if (r_need[1] && xif_register_rs_valid_i[1])
            r_rs2 <= xif_register_rs2_i;
          if (r_need[2] && xif_register_rs_valid_i[2])
            r_rs3 <= xif_register_rs3_i;
          r_got    <= w_got;
          r_commit <= w_cmt;
          if (w_kill) begin
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rs3   <= '0;
            r_got   <= '0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_all && w_cmt) begin
            r_cnt   <= LAT;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt <= 4'd1) begin
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_we    <= r_wb;
            r_data  <= r_wb ? w_res : 32'd0;
            r_state <= S_RESULT;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESULT: begin
          if (xif_result_ready_i) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_data  <= '0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign xif_issue_ready_o  = r_ready;
  assign xif_result_valid_o = r_valid;
  assign xif_result_we_o    = r_we;
  assign xif_result_data_o  = r_data;

endmodule

// File: doc/cve2_xif_coproc.md
CVE2_XIF_COPROC -- requirements
Module: cve2_xif_coproc

Interface
REQ-001 SHALL have parameter ExecLatency, default 2, execute-stage cycles (legal 1..15).
REQ-002 SHALL have port clk_i  input  1  clock; all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL have port xif_issue_valid_i  input  1  core offers instruction.
REQ-005 SHALL have port xif_issue_req_instr_i  input  32  offered instruction word.
REQ-006 SHALL have port xif_issue_ready_o  output  1  coprocessor can take an issue.
REQ-007 SHALL have port xif_issue_resp_accept_o  output  1  instruction is ours.
REQ-008 SHALL have port xif_issue_resp_writeback_o  output  1  accepted instruction writes rd.
REQ-009 SHALL have port xif_issue_resp_register_read_o  output  3  operands needed, bit i = rs(i+1).
REQ-010 SHALL have port xif_register_rs1_i  input  32  operand 1.
REQ-011 SHALL have port xif_register_rs2_i  input  32  operand 2.
REQ-012 SHALL have port xif_register_rs3_i  input  32  operand 3.
REQ-013 SHALL have port xif_register_rs_valid_i  input  3  per-operand valid.
REQ-014 SHALL have port xif_commit_valid_i  input  1  commit/kill strobe for outstanding instruction.
REQ-015 SHALL have port xif_commit_kill_i  input  1  qualifies commit as kill.
REQ-016 SHALL have port xif_result_ready_i  input  1  core accepts result.
REQ-017 SHALL have port xif_result_valid_o  output  1  result presented.
REQ-018 SHALL have port xif_result_we_o  output  1  result writes rd.
REQ-019 SHALL have port xif_result_data_o  output  32  result value.

Function
REQ-020 SHALL decode opcode instr[6:0]=7'b0001011 (custom-0); funct3: 000 CADD rd=rs1+rs2; 001 CMUL16 rd=rs1[15:0]*rs2[15:0] unsigned; 010 CMAC rd=rs1[15:0]*rs2[15:0]+rs3 (rs3=instr[31:27]), mod 2^32; 011 CPOPC rd=popcount(rs1), zero-extended.
REQ-021 SHALL drive accept/writeback/register_read combinationally from instr whenever issue_valid_i; non-matching opcode or funct3 1xx -> accept=0, writeback=0, register_read=0.
REQ-022 SHALL set register_read: CADD/CMUL16 3'b011, CMAC 3'b111, CPOPC 3'b001; writeback=1 iff accepted and rd (instr[11:7]) != 0.
REQ-023 SHALL use FSM IDLE, OPERANDS, EXEC, RESULT; issue_ready_o=1 only in IDLE.
REQ-024 IDLE: issue_valid&ready&accept -> latch op, writeback, needed mask; go OPERANDS; rejected issue -> stay IDLE.
REQ-025 OPERANDS: capture each needed operand in the cycle its rs_valid bit is 1 (bits may arrive in any cycle, including the issue-accept cycle +1 onward); latch commit strobe when it arrives; leave when all needed operands captured AND commit seen.
REQ-026 commit with kill=1 in OPERANDS, or arriving in same cycle as last operand, -> IDLE, no result, operands discarded.
REQ-027 commit with kill=0 plus all operands -> EXEC; EXEC lasts exactly ExecLatency cycles (down-counter), then RESULT.
REQ-028 RESULT: result_valid_o=1, data and we stable until result_ready_i=1; handshake cycle -> IDLE; next issue may be taken one cycle later.
REQ-029 xif_result_we_o SHALL equal latched writeback; data SHALL be zero when we=0.
REQ-030 Commit strobes in IDLE, EXEC or RESULT SHALL be ignored.

Reset
REQ-031 rst_ni low SHALL asynchronously force IDLE, counter 0, operand/latch registers 0, result_valid_o=0, xif_result_we_o=0, xif_result_data_o=0, xif_issue_ready_o=1.
REQ-032 Reset mid-operation SHALL abandon the instruction with no result emitted after release.

Structure
REQ-033 SHALL place custom-0 opcode constant, funct3 enum (xif_cop_op_e) and FSM state enum in cve2_pkg.
REQ-034 SHALL isolate datapath in one combinational sub-module cve2_xif_coproc_alu (op, rs1..rs3 -> 32-bit result).

Verification
REQ-035 CADD rd=x5, rs1=5, rs2=7, commit kill=0, ready=1 -> after ExecLatency cycles result_valid=1, data=12, we=1.
REQ-036 CMAC rs1=0x0001_FFFF, rs2=0x0000_0002, rs3=0xFFFF_FFFF -> data=0x0001_FFFD (0x1FFFE+0xFFFFFFFF mod 2^32).
REQ-037 opcode 7'b0110011 offered -> accept=0, register_read=0, ready stays 1, no result.
REQ-038 CPOPC rs1=0xF0F0_0001, rd=x0 -> result data=0, we=0; ready held 0 for 3 cycles -> valid/data stable, IDLE after handshake.
REQ-039 CADD with kill=1 before rs2 valid -> no result_valid, ready=1 next cycle; rst_ni low in EXEC -> all outputs at reset values.
